// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle click, double-click,
// long-press and auto-repeat pulses using one shared state timer.
module button_event #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DBL_CYC    = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned CNT_W      = 26,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic PRESSED,
    output logic CLICK,
    output logic DOUBLE,
    output logic LONG,
    output logic REPEAT
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    state_t           state;
    logic             p;
    logic [CNT_W-1:0] cnt;

    assign PRESSED = p;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= 1'b0;
            CLICK  <= 1'b0;
            DOUBLE <= 1'b0;
            LONG   <= 1'b0;
            REPEAT <= 1'b0;
        end else begin
            p      <= IN ^ ACTIVE_LOW;
            CLICK  <= 1'b0;
            DOUBLE <= 1'b0;
            LONG   <= 1'b0;
            REPEAT <= 1'b0;
            cnt    <= cnt + 1'b1;
            // Level changes are tested before timeouts so they win on the final count.
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (!p) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        LONG  <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (p) begin
                        state  <= PRESS2;
                        cnt    <= '0;
                        DOUBLE <= 1'b1;
                    end else if (cnt == DBL_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        CLICK <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                HELD: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt    <= '0;
                        REPEAT <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: one active-high instance with short
// timeouts, plus an active-low instance for the polarity case.
module tb_button_event;

    logic clk = 1'b0;
    logic rst;
    logic in_a, in_b;
    logic pressed_a, click_a, double_a, long_a, repeat_a;
    logic pressed_b, click_b, double_b, long_b, repeat_b;

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;

    int n_click, n_dbl, n_long, n_rep, e_click, e_dbl, e_long;
    int rep_e[$];
    int n_click_b, e_click_b, n_other_b;

    always #5 clk = ~clk;

    button_event #(
        .LONG_CYC(20), .DBL_CYC(10), .REPEAT_CYC(5), .CNT_W(5), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .CLK(clk), .RST(rst), .IN(in_a), .PRESSED(pressed_a), .CLICK(click_a),
        .DOUBLE(double_a), .LONG(long_a), .REPEAT(repeat_a)
    );

    button_event #(
        .LONG_CYC(20), .DBL_CYC(10), .REPEAT_CYC(5), .CNT_W(5), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .CLK(clk), .RST(rst), .IN(in_b), .PRESSED(pressed_b), .CLICK(click_b),
        .DOUBLE(double_b), .LONG(long_b), .REPEAT(repeat_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        n_click = 0; n_dbl = 0; n_long = 0; n_rep = 0;
        e_click = -1; e_dbl = -1; e_long = -1;
        rep_e.delete();
        n_click_b = 0; e_click_b = -1; n_other_b = 0;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (click_a)  begin n_click++; e_click = edge_n; end
        if (double_a) begin n_dbl++;   e_dbl   = edge_n; end
        if (long_a)   begin n_long++;  e_long  = edge_n; end
        if (repeat_a) begin n_rep++;   rep_e.push_back(edge_n); end
        if (click_b)  begin n_click_b++; e_click_b = edge_n; end
        if (double_b || long_b || repeat_b) n_other_b++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_release(input int hold, output int t0, output int r);
        in_a = 1'b1;
        t0 = edge_n + 1;
        run(hold);
        in_a = 1'b0;
        r = edge_n + 1;
    endtask

    initial begin
        int t0, r, s, r2;

        rst  = 1'b1;
        in_a = 1'b0;
        in_b = 1'b1;
        clear_events();
        run(2);
        check("reset_outs_a", {pressed_a, click_a, double_a, long_a, repeat_a}, 0);
        check("reset_outs_b", {pressed_b, click_b, double_b, long_b, repeat_b}, 0);
        #2 rst = 1'b0;
        run(3);
        check("idle_pressed_b", pressed_b, 0);

        // Single click
        clear_events();
        in_a = 1'b1;
        t0 = edge_n + 1;
        step();
        check("click_pressed", pressed_a, 1);
        run(4);
        in_a = 1'b0;
        r = edge_n + 1;
        run(20);
        check("click_count", n_click, 1);
        check("click_edge", e_click - r, 11);
        check("click_others", n_dbl + n_long + n_rep, 0);

        // Double click
        clear_events();
        press_release(5, t0, r);
        run(4);
        in_a = 1'b1;
        s = edge_n + 1;
        run(5);
        in_a = 1'b0;
        run(20);
        check("dbl_count", n_dbl, 1);
        check("dbl_edge", e_dbl - s, 1);
        check("dbl_no_click", n_click + n_long + n_rep, 0);

        // Long press with auto-repeat
        clear_events();
        press_release(38, t0, r);
        run(20);
        check("long_count", n_long, 1);
        check("long_edge", e_long - t0, 21);
        check("rep_count", n_rep, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("rep_edge%0d", i),
                  (i < rep_e.size()) ? rep_e[i] - t0 : -1, 26 + 5 * i);
        check("long_no_click", n_click + n_dbl, 0);

        // Release lands on final PRESS1 count: no LONG, CLICK follows
        clear_events();
        press_release(20, t0, r);
        run(20);
        check("b1_no_long", n_long, 0);
        check("b1_click_count", n_click, 1);
        check("b1_click_edge", e_click - t0, 31);

        // Second press lands on final WAIT2 count: DOUBLE wins over CLICK
        clear_events();
        press_release(5, t0, r);
        run(10);
        in_a = 1'b1;
        s = edge_n + 1;
        run(5);
        in_a = 1'b0;
        run(20);
        check("b2_dbl_count", n_dbl, 1);
        check("b2_dbl_edge", e_dbl - r, 11);
        check("b2_no_click", n_click, 0);

        // Release lands on a repeat count in HELD: no REPEAT
        clear_events();
        press_release(25, t0, r);
        run(20);
        check("b3_long_count", n_long, 1);
        check("b3_no_repeat", n_rep, 0);
        check("b3_no_click", n_click, 0);

        // Asynchronous reset inside WAIT2, button held across reset
        clear_events();
        press_release(5, t0, r);
        run(5);
        in_a = 1'b1;
        step();
        check("rst_pre_pressed", pressed_a, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outs", {pressed_a, click_a, double_a, long_a, repeat_a}, 0);
        run(3);
        check("rst_held_pressed", pressed_a, 0);
        #2 rst = 1'b0;
        t0 = edge_n + 1;
        run(5);
        in_a = 1'b0;
        r2 = edge_n + 1;
        run(20);
        check("rst_no_double", n_dbl, 0);
        check("rst_new_click", n_click, 1);
        check("rst_click_edge", e_click - r2, 11);

        // Active-low instance
        clear_events();
        in_b = 1'b0;
        t0 = edge_n + 1;
        step();
        check("pol_pressed_hi", pressed_b, 1);
        run(4);
        in_b = 1'b1;
        r = edge_n + 1;
        step();
        check("pol_pressed_lo", pressed_b, 0);
        run(19);
        check("pol_click_count", n_click_b, 1);
        check("pol_click_edge", e_click_b - r, 11);
        check("pol_others", n_other_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
